mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised load/store unit for the MEM stage of the RISC-V pipeline. Selects the store operand from the EX/MEM value or one of NFWD forwarding sources, and generates byte lanes for byte, half and word accesses (double on XLEN=64). Drives a variable-latency request/grant/rvalid data-memory port and returns sign- or zero-extended load data. Stalls the pipeline until the access completes, or until it faults on misalignment or bus timeout.

## Interface
- XLEN, 32: datapath width, 32 or 64
- NFWD, 2: number of store-data forwarding sources
- TIMEOUT, 0: max cycles in REQ+WAIT before bus error; 0 disables
- clk in 1: clock
- rst in 1: synchronous, active-high reset
- mem_valid_i in 1: load/store present in MEM
- mem_we_i in 1: 1 = store, 0 = load
- mem_size_i in 2: 0 byte, 1 half, 2 word, 3 double (XLEN=64 only)
- mem_unsigned_i in 1: zero-extend load
- addr_i in XLEN: byte address
- rd_data_mem_i in XLEN: store data from EX/MEM
- fwd_sel_i in clog2(NFWD+1): 0 = rd_data_mem_i, k = source k
- fwd_data_i in NFWD*XLEN: forwarding sources; source k in slice k-1
- dmem_req_o out 1, dmem_gnt_i in 1: request/grant
- dmem_we_o out 1, dmem_addr_o out XLEN (lane-aligned), dmem_be_o out XLEN/8, dmem_wdata_o out XLEN
- dmem_rvalid_i in 1, dmem_rdata_i in XLEN: load response
- load_data_o out XLEN: extended load result, valid with done_o
- done_o out 1: one-cycle completion pulse
- stall_o out 1: hold upstream stages
- misalign_o out 1, bus_err_o out 1: fault flags, valid with done_o

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_valid_i and aligned: capture we, size, unsigned, addr, and selected store data (mux by fwd_sel_i); go to REQ.
  - If misaligned (half with addr[0]; word with addr[1:0]≠0; double with addr[2:0]≠0; size 3 on XLEN=32): go to DONE with misalign set. No bus request.
- Captured operands are frozen for the rest of the access. Later forwarding changes are ignored.
- REQ:
  - dmem_req_o=1 with stable addr/be/we/wdata until dmem_gnt_i.
  - On grant: store goes to DONE; load goes to WAIT.
- WAIT: on dmem_rvalid_i, extract the lane at addr offset, extend per size/unsigned, register it into load_data_o, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. Flags hold their value only during DONE.
- Byte enables: byte = 1<<off; half = 3<<off; word = 0xF<<off; double = all. wdata = data replicated into the addressed lane.
- Timeout (TIMEOUT>0): counter clears on entry to REQ and counts every REQ/WAIT cycle. On reaching TIMEOUT: go to DONE with bus_err_o=1, drop the request, ignore a late rvalid.
- rvalid outside WAIT is ignored.
- Reset values: state IDLE, all outputs 0.
- Reset mid-access abandons the access; dmem_req_o is 0 from the cycle after reset is sampled.

## Timing
- stall_o = mem_valid_i & (state≠DONE), combinational. The pipeline advances in the done_o cycle.
- Store, immediate grant: IDLE (c0), REQ (c1, gnt), DONE (c2). 3 cycles, 2 stalled.
- Load, immediate grant, rvalid next cycle: c0 IDLE, c1 REQ, c2 WAIT, c3 DONE.
- Misaligned access: c0 IDLE, c1 DONE.
- load_data_o is registered and holds until the next load completes.
- One outstanding access, no pipelining.
- mem_valid_i must stay high until done_o. A drop before done_o leaves the current access running; its result is discarded.

## Structure
- mem_lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - state enum
  - function for misalign check
- Sub-module mem_lsu_align (combinational): BE/wdata lane placement and load extraction/extension. Parametrised by XLEN, reused by the FSM top.

## Test plan
- Store byte, XLEN=32: addr 0x1003, data 0x000000A5, sel 0, gnt at REQ → be=0x8, wdata=0xA5A5A5A5, addr=0x1000, done_o at c2.
- Forwarding: sel=2, source 2 = 0xDEADBEEF, word store; source 2 changes during a 3-cycle grant delay → wdata=0xDEADBEEF throughout.
- Signed half load: addr 0x2002, rdata 0x80F00000 → load_data_o=0xFFFF80F0. Unsigned → 0x000080F0.
- Misaligned word: addr 0x2001 → no dmem_req_o, misalign_o=1 and done_o=1 at c1, stall_o=1 at c0 only.
- Timeout: TIMEOUT=4, load granted, no rvalid → bus_err_o with done_o 4 cycles after REQ entry. rvalid at +6 is ignored.
- Reset mid-WAIT, then new load → next request issues normally. The stale rvalid arriving in IDLE has no effect.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the alignment rule applied before any bus request is issued.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // An access is misaligned when its address is not a multiple of its size.
  // A double access is never legal on a 32-bit datapath.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo,
                                         input logic       xlen64);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      default: mis = !xlen64 || (|addr_lo);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane placement for the data-memory port: byte enables and replicated store
// data for writes, lane extraction plus sign/zero extension for loads.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0]   off_i,
  input  logic [XLEN-1:0]             data_i,
  input  logic [XLEN-1:0]             rdata_i,
  output logic [XLEN/8-1:0]           be_o,
  output logic [XLEN-1:0]             wdata_o,
  output logic [XLEN-1:0]             load_o
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0] be_mask;

  // Store side: size mask shifted to the addressed lane, data copied into every lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    be_mask = '0;
    wdata_o = '0;
    case (size_i)
      SZ_B:    be_mask = NB'(1);
      SZ_H:    be_mask = NB'(3);
      SZ_W:    be_mask = NB'(15);
      default: be_mask = '1;
    endcase
    be_o = be_mask << off_i;
    for (int i = 0; i < NB; i++) begin
      case (size_i)
        SZ_B:    wdata_o[8*i +: 8] = data_i[7:0];
        SZ_H:    wdata_o[8*i +: 8] = data_i[8*(i%2) +: 8];
        SZ_W:    wdata_o[8*i +: 8] = data_i[8*(i%4) +: 8];
        default: wdata_o[8*i +: 8] = data_i[8*i +: 8];
      endcase
    end
  end

  logic [XLEN-1:0] shifted;
  logic            msb;
  logic            fill;
  int              nbits;

  // Load side: bring the addressed lane down to bit 0, then extend above its width.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B:    begin nbits = 8;    msb = shifted[7];      end
      SZ_H:    begin nbits = 16;   msb = shifted[15];     end
      SZ_W:    begin nbits = 32;   msb = shifted[31];     end
      default: begin nbits = XLEN; msb = shifted[XLEN-1]; end
    endcase
    fill = msb & ~unsigned_i;
    for (int i = 0; i < XLEN; i++) begin
      load_o[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: captures one access, drives a request/grant/rvalid
// data-memory port, and reports completion, misalignment or bus timeout.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NFWD    = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_valid_i,
  input  logic                        mem_we_i,
  input  logic [1:0]                  mem_size_i,
  input  logic                        mem_unsigned_i,
  input  logic [XLEN-1:0]             addr_i,
  input  logic [XLEN-1:0]             rd_data_mem_i,
  input  logic [$clog2(NFWD+1)-1:0]   fwd_sel_i,
  input  logic [NFWD*XLEN-1:0]        fwd_data_i,
  output logic                        dmem_req_o,
  input  logic                        dmem_gnt_i,
  output logic                        dmem_we_o,
  output logic [XLEN-1:0]             dmem_addr_o,
  output logic [XLEN/8-1:0]           dmem_be_o,
  output logic [XLEN-1:0]             dmem_wdata_o,
  input  logic                        dmem_rvalid_i,
  input  logic [XLEN-1:0]             dmem_rdata_i,
  output logic [XLEN-1:0]             load_data_o,
  output logic                        done_o,
  output logic                        stall_o,
  output logic                        misalign_o,
  output logic                        bus_err_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SELW = $clog2(NFWD + 1);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;
  logic [XLEN-1:0] load_q, load_d;

  logic [XLEN-1:0] store_sel;
  logic [NB-1:0]   lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_ext;
  logic            timeout_hit;

  // Store operand: EX/MEM value unless a forwarding source is selected.
  always_comb begin
    store_sel = rd_data_mem_i;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_sel_i == SELW'(k)) store_sel = fwd_data_i[(k-1)*XLEN +: XLEN];
    end
  end

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[OFFW-1:0]),
    .data_i     (data_q),
    .rdata_i    (dmem_rdata_i),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .load_o     (load_ext)
  );

  // The counter holds TIMEOUT-1 in the last REQ/WAIT cycle the access may use.
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next state, operand capture, timeout counting and fault flags.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i) begin
          if (is_misaligned(mem_size_i, addr_i[2:0], XLEN == 64)) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = mem_we_i;
            size_d  = mem_size_i;
            uns_d   = mem_unsigned_i;
            addr_d  = addr_i;
            data_d  = store_sel;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_gnt_i && we_q) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end else if (dmem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_rvalid_i) begin
          load_d  = load_ext;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: operand registers are reset alongside the state so every output is zero out of reset.
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      load_q  <= load_d;
    end
  end

  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign dmem_be_o    = dmem_req_o ? lane_be : '0;
  assign dmem_wdata_o = dmem_req_o ? lane_wdata : '0;

  assign load_data_o  = load_q;
  assign done_o       = (state_q == ST_DONE);
  assign stall_o      = mem_valid_i & (state_q != ST_DONE);
  assign misalign_o   = mis_q;
  assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised self-checking bench for mem_lsu (XLEN=32, NFWD=2, TIMEOUT=4)
// against a behavioural model of lanes, extension and access timing.
module tb_mem_lsu;

  localparam int XLEN    = 32;
  localparam int NFWD    = 2;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid_i, mem_we_i, mem_unsigned_i;
  logic [1:0]        mem_size_i;
  logic [XLEN-1:0]   addr_i, rd_data_mem_i;
  logic [1:0]        fwd_sel_i;
  logic [NFWD*XLEN-1:0] fwd_data_i;
  logic              dmem_req_o, dmem_gnt_i, dmem_we_o;
  logic [XLEN-1:0]   dmem_addr_o, dmem_wdata_o;
  logic [XLEN/8-1:0] dmem_be_o;
  logic              dmem_rvalid_i;
  logic [XLEN-1:0]   dmem_rdata_i, load_data_o;
  logic              done_o, stall_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_load;

  mem_lsu #(.XLEN(XLEN), .NFWD(NFWD), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid_i    (mem_valid_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .addr_i         (addr_i),
    .rd_data_mem_i  (rd_data_mem_i),
    .fwd_sel_i      (fwd_sel_i),
    .fwd_data_i     (fwd_data_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .load_data_o    (load_data_o),
    .done_o         (done_o),
    .stall_o        (stall_o),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    int nb = 1 << size;
    if (nb > XLEN / 8) return 1'b1;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int nb = 1 << size;
    int off = addr % 4;
    logic [3:0] be = '0;
    for (int b = 0; b < nb; b++) be[off + b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] data);
    int nb = 1 << size;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    int nb = 1 << size;
    logic [31:0] v = rdata >> (8 * (addr % 4));
    logic [31:0] mask;
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic scramble_inputs();
    mem_we_i       = 1'($urandom);
    mem_size_i     = 2'($urandom);
    mem_unsigned_i = 1'($urandom);
    addr_i         = $urandom;
    rd_data_mem_i  = $urandom;
    fwd_data_i     = {$urandom, $urandom};
    fwd_sel_i      = 2'($urandom_range(0, NFWD));
  endtask

  // One access from c0 to its done cycle; timing and results come from the model.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] data,
                            input int sel, input int gdly, input int rdly,
                            input logic [31:0] rdata);
    bit mis, ok;
    int total, dcyc;
    mis   = m_misaligned(size, addr);
    total = we ? gdly : gdly + rdly;
    ok    = !mis && (total <= TIMEOUT);
    dcyc  = mis ? 1 : (ok ? total + 1 : TIMEOUT + 1);
    @(negedge clk);
    mem_valid_i    = 1'b1;
    mem_we_i       = we;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    addr_i         = addr;
    fwd_sel_i      = 2'(sel);
    rd_data_mem_i  = (sel == 0) ? data : $urandom;
    fwd_data_i     = {(sel == 2) ? data : $urandom, (sel == 1) ? data : $urandom};
    #1;
    check({tag, " c0 stall"}, stall_o, 1);
    check({tag, " c0 req"}, dmem_req_o, 0);
    check({tag, " c0 done"}, done_o, 0);
    for (int cyc = 1; cyc <= dcyc; cyc++) begin
      @(negedge clk);
      check({tag, " done"}, done_o, cyc == dcyc);
      if (cyc < dcyc) begin
        check({tag, " flags idle"}, {misalign_o, bus_err_o}, 0);
        check({tag, " stall"}, stall_o, 1);
        if (cyc <= gdly) begin
          check({tag, " req"}, dmem_req_o, 1);
          check({tag, " we"}, dmem_we_o, we);
          check({tag, " addr"}, dmem_addr_o, addr & ~32'h3);
          check({tag, " be"}, dmem_be_o, m_be(size, addr));
          if (we) check({tag, " wdata"}, dmem_wdata_o, m_wdata(size, data));
        end else begin
          check({tag, " req wait"}, dmem_req_o, 0);
        end
        scramble_inputs();
        mem_valid_i   = 1'b1;
        dmem_gnt_i    = (cyc == gdly);
        dmem_rvalid_i = 1'b0;
        if (!we && cyc == gdly + rdly) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rdata;
        end else if (cyc <= gdly) begin
          dmem_rvalid_i = 1'($urandom);
          dmem_rdata_i  = $urandom;
        end
      end else begin
        if (ok && !we) exp_load = m_load(size, uns, addr, rdata);
        check({tag, " misalign"}, misalign_o, mis);
        check({tag, " bus_err"}, bus_err_o, !mis && !ok);
        check({tag, " load_data"}, load_data_o, exp_load);
        check({tag, " stall done"}, stall_o, 0);
        check({tag, " req done"}, dmem_req_o, 0);
      end
    end
    mem_valid_i   = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  // Idle cycles; mode 0 quiet, 1 random stray rvalid, 2 rvalid every cycle.
  task automatic idle(input string tag, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " idle done"}, done_o, 0);
      check({tag, " idle req"}, dmem_req_o, 0);
      check({tag, " idle load_data"}, load_data_o, exp_load);
      dmem_rvalid_i = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
      dmem_rdata_i  = $urandom;
    end
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0; mem_unsigned_i = 1'b0;
    addr_i = '0; rd_data_mem_i = '0; fwd_sel_i = '0; fwd_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    exp_load = '0;
    repeat (3) @(negedge clk);
    check("rst req", dmem_req_o, 0);
    check("rst we", dmem_we_o, 0);
    check("rst addr", dmem_addr_o, 0);
    check("rst be", dmem_be_o, 0);
    check("rst wdata", dmem_wdata_o, 0);
    check("rst load_data", load_data_o, 0);
    check("rst done", done_o, 0);
    check("rst stall", stall_o, 0);
    check("rst flags", {misalign_o, bus_err_o}, 0);
    rst = 1'b0;

    run_access("st_byte", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 0, 1, 1, 32'h0);
    run_access("fwd_word", 1'b1, 2'd2, 1'b0, 32'h4000, 32'hDEAD_BEEF, 2, 4, 1, 32'h0);
    run_access("ld_h_s", 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 0, 1, 1, 32'h80F0_0000);
    check("ld_h_s value", load_data_o, 32'hFFFF_80F0);
    run_access("ld_h_u", 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 0, 1, 1, 32'h80F0_0000);
    check("ld_h_u value", load_data_o, 32'h0000_80F0);
    run_access("mis_word", 1'b1, 2'd2, 1'b0, 32'h2001, 32'h1234, 0, 1, 1, 32'h0);
    run_access("timeout", 1'b0, 2'd2, 1'b0, 32'h2100, 32'h0, 0, 1, 20, 32'h5555_AAAA);
    idle("late_rvalid", 4, 2);

    // Reset while the load waits for rvalid; a stale rvalid then lands in IDLE.
    @(negedge clk);
    mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2; addr_i = 32'h3000;
    @(negedge clk);
    check("rstw req", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    check("rstw wait req", dmem_req_o, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstw req after", dmem_req_o, 0);
    check("rstw done after", done_o, 0);
    check("rstw load_data", load_data_o, 0);
    rst = 1'b0;
    mem_valid_i = 1'b0;
    exp_load = '0;
    idle("stale_rvalid", 2, 2);
    run_access("after_rst", 1'b0, 2'd0, 1'b0, 32'h3001, 32'h0, 0, 1, 1, 32'h0000_9900);

    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      run_access($sformatf("rnd%0d", t), 1'($urandom), sz, 1'($urandom), a, $urandom,
                 $urandom_range(0, NFWD), $urandom_range(1, 3), $urandom_range(1, 3), $urandom);
      if ($urandom_range(0, 1) != 0) idle($sformatf("rnd%0d", t), $urandom_range(1, 2), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
